aes128_inv_cipher_iter: RTL and testbench

- Iterative AES-128 decryption core, one inverse round per clock.
- Mirror of the encryption datapath: InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns. The final inverse round omits InvMixColumns.
- Sits between the key-schedule register file, which serves round keys by index, and the block-level stream interface.
- Accepts one ciphertext block with valid/ready and returns the plaintext with valid/ready.

---
 rtl/aes_pkg.sv | 72 +++++++
 rtl/inv_sub_byte.sv | 26 ++
 rtl/aes128_inv_cipher_iter.sv | 87 ++++++++
 tb/tb_aes128_inv_cipher_iter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the decryption datapath: block constants,
// FSM state type and GF(2^8) helpers (reduction polynomial 0x11B).
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add form.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] av;
    logic [7:0] bv;
    p  = '0;
    av = a;
    bv = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bv[0]) p = p ^ av;
      av = xtime(av);
      bv = bv >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_mul_09(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] gf_mul_0b(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] gf_mul_0d(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] gf_mul_0e(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

  // Row r rotates right by r; bytes are column-major, byte 0 in [127:120].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    return {s[127:120], s[23:16],  s[47:40],  s[71:64],
            s[95:88],   s[119:112], s[15:8],  s[39:32],
            s[63:56],   s[87:80],  s[111:104], s[7:0],
            s[31:24],   s[55:48],  s[79:72],  s[103:96]};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul_0e(a0) ^ gf_mul_0b(a1) ^ gf_mul_0d(a2) ^ gf_mul_09(a3),
            gf_mul_09(a0) ^ gf_mul_0e(a1) ^ gf_mul_0b(a2) ^ gf_mul_0d(a3),
            gf_mul_0d(a0) ^ gf_mul_09(a1) ^ gf_mul_0e(a2) ^ gf_mul_0b(a3),
            gf_mul_0b(a0) ^ gf_mul_0d(a1) ^ gf_mul_09(a2) ^ gf_mul_0e(a3)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
  endfunction

endpackage

// File: rtl/inv_sub_byte.sv
// 16 parallel AES inverse S-box lookups, purely combinational.
module inv_sub_byte
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] blk,
  output logic [AES_BLK_W-1:0] sub_blk
);

  // Inverse S-box computed as inverse affine map followed by the
  // multiplicative inverse x^254 (0 maps to 0), avoiding a 256-entry table.
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] a;
    logic [7:0] t;
    a = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    t = a;
    for (int unsigned i = 0; i < 6; i++) begin
      t = gf_mul(gf_mul(t, t), a);
    end
    return gf_mul(t, t);
  endfunction

  for (genvar g = 0; g < 16; g++) begin : g_byte
    assign sub_blk[8*g +: 8] = inv_sbox(blk[8*g +: 8]);
  end

endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 decryption core: one inverse round per clock, round keys
// fetched by index from an external key-schedule register file.
module aes128_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR       = AES_NR,
  parameter int RK_IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AES_BLK_W-1:0]  in_data,
  output logic [RK_IDX_W-1:0]   rk_idx,
  input  logic [AES_BLK_W-1:0]  rk_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AES_BLK_W-1:0]  out_data,
  output logic                  busy
);

  state_t                 state;
  logic [RK_IDX_W-1:0]    rnd;
  logic [AES_BLK_W-1:0]   st;
  logic [AES_BLK_W-1:0]   isr;
  logic [AES_BLK_W-1:0]   isb;
  logic [AES_BLK_W-1:0]   ark;
  logic [AES_BLK_W-1:0]   imc;

  assign isr = inv_shift_rows(st);

  inv_sub_byte u_inv_sub_byte (
    .blk     (isr),
    .sub_blk (isb)
  );

  assign ark = isb ^ rk_data;
  assign imc = inv_mix_columns(ark);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = st;

  // Round-key index: last key while idle, current round while iterating.
  always_comb begin
    rk_idx = '0;
    case (state)
      IDLE:    rk_idx = RK_IDX_W'(NR);
      ROUND:   rk_idx = rnd;
      default: rk_idx = '0;
    endcase
  end

  // Control FSM and round-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rnd   <= '0;
      st    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= in_data ^ rk_data;
            rnd   <= RK_IDX_W'(NR - 1);
            state <= ROUND;
          end
        end
        ROUND: begin
          if (rnd == '0) begin
            st    <= ark;
            state <= DONE;
          end else begin
            st  <= imc;
            rnd <= rnd - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// Directed bench for the iterative AES-128 decryption core.
module tb_aes128_inv_cipher_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  aes128_inv_cipher_iter #(.NR(10), .RK_IDX_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t         vecs [2];
  logic [127:0] rk_tab [0:10];
  logic [7:0]   sbox_t [256];
  logic         noise_en;
  logic [127:0] noise_val;
  int           n_tests;
  int           n_fail;
  int           cyc;
  int           acc_q [$];

  // Key-schedule register file model: combinational lookup by index.
  always_comb begin
    rk_data = '0;
    if (noise_en) rk_data = noise_val;
    else if (rk_idx <= 4'd10) rk_data = rk_tab[rk_idx];
  end

  // Log the cycle number of every accepted ciphertext.
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  function automatic logic [7:0] tb_xt(input logic [7:0] x);
    return x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    while (y != 8'h00) begin
      if (y[0]) p ^= x;
      x = tb_xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Forward S-box from first principles: brute-force inverse, then affine map.
  task automatic build_sbox();
    logic [7:0] bx, inv, bv;
    for (int x = 0; x < 256; x++) begin
      bx  = x[7:0];
      inv = 8'h00;
      for (int v = 1; v < 256; v++) begin
        bv = v[7:0];
        if (tb_gmul(bx, bv) == 8'h01) inv = bv;
      end
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = tb_xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one block, accept it, then follow the rounds until out_valid.
  // Returns at #1 after the edge where out_valid first rises.
  task automatic run_block(input logic [127:0] ct, output logic [127:0] pt,
                           output int lat, output bit seq_ok);
    int g;
    int k;
    seq_ok = 1'b1;
    @(negedge clk);
    in_data  = ct;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (rk_idx !== 4'd10) seq_ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    k = 0;
    while (!out_valid && k < 40) begin
      if (rk_idx !== 4'(9 - k)) seq_ok = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
    lat = k;
    pt  = out_data;
  endtask

  initial begin
    logic [127:0] pt;
    logic [127:0] ref_d;
    int           lat;
    bit           seq_ok;
    bit           ok;
    int           k;

    n_tests   = 0;
    n_fail    = 0;
    cyc       = 0;
    noise_en  = 1'b0;
    noise_val = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;

    vecs[0] = '{"c1", 128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{"b",  128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};

    build_sbox();
    load_key(vecs[0].key);

    // Reset values
    #2;
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_rk_idx",    128'(rk_idx),    128'd10);
    check("rst_out_data",  out_data,        128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven known-answer decrypts
    for (int v = 0; v < 2; v++) begin
      load_key(vecs[v].key);
      run_block(vecs[v].ct, pt, lat, seq_ok);
      check({vecs[v].name, "_pt"},      pt,          vecs[v].pt);
      check({vecs[v].name, "_latency"}, 128'(lat),   128'd10);
      check({vecs[v].name, "_rk_seq"},  128'(seq_ok), 128'd1);
      check({vecs[v].name, "_busy"},    128'(busy),  128'd1);
      @(posedge clk);
      #1;
      check({vecs[v].name, "_ovalid_drop"}, 128'(out_valid), 128'd0);
      check({vecs[v].name, "_iready_back"}, 128'(in_ready),  128'd1);
    end

    // Back-pressure: output held 20 cycles, new input refused
    load_key(vecs[0].key);
    out_ready = 1'b0;
    run_block(vecs[0].ct, pt, lat, seq_ok);
    check("bp_pt", pt, vecs[0].pt);
    ref_d = out_data;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      if (out_data !== ref_d || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    check("bp_hold_stable", 128'(ok), 128'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_iready", 128'(in_ready),  128'd1);
    check("bp_release_ovalid", 128'(out_valid), 128'd0);
    @(posedge clk);
    #1;
    check("bp_no_accept", 128'(busy), 128'd0);

    // Back-to-back with in_valid held high
    acc_q.delete();
    load_key(vecs[0].key);
    @(negedge clk);
    in_data  = vecs[0].ct;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = vecs[1].ct;
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("b2b_first_pt", out_data, vecs[0].pt);
    load_key(vecs[1].key);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("b2b_second_pt", out_data, vecs[1].pt);
    check("b2b_accepts", 128'(acc_q.size()), 128'd2);
    if (acc_q.size() == 2)
      check("b2b_spacing", 128'(acc_q[1] - acc_q[0]), 128'd12);
    @(posedge clk);
    #1;

    // Asynchronous reset during round 5
    load_key(vecs[0].key);
    @(negedge clk);
    in_data  = vecs[0].ct;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_rk_idx_round5", 128'(rk_idx), 128'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  128'(in_ready),  128'd1);
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_rk_idx",    128'(rk_idx),    128'd10);
    check("mid_rst_busy",      128'(busy),      128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(vecs[0].ct, pt, lat, seq_ok);
    check("mid_rst_redo_pt", pt, vecs[0].pt);
    @(posedge clk);
    #1;

    // Idle noise on out_ready and rk_data
    noise_en = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      noise_val = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("idle_noise_quiet", 128'(ok), 128'd1);
    noise_en  = 1'b0;
    out_ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
